// File: rtl/cpu_pkg.sv
// Shared types for the CPU fetch path.
// addr_t / data_t match the 2048x8 program memory (cpumemory) port widths.
// fetch_state_t enumerates the instruction assembler states.
// instr_len() extracts the opcode length code; LEN_* name its values.
package cpu_pkg;

    typedef logic [10:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic [1:0] {
        S_OP,
        S_ARG1,
        S_ARG2
    } fetch_state_t;

    localparam logic [1:0] LEN_1   = 2'b00;
    localparam logic [1:0] LEN_2   = 2'b01;
    localparam logic [1:0] LEN_3   = 2'b10;
    localparam logic [1:0] LEN_ILL = 2'b11;

    function automatic logic [1:0] instr_len(data_t op);
        return op[7:6];
    endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Fetch-stage bus bundle.
//   mem_addr/mem_readwrite/mem_data : program memory read port
//   branch_valid/branch_addr        : redirect request from the branch unit
//   instr_*                         : valid/ready instruction handshake to the decoder
// master = fetch stage, slave = memory/branch/decoder side.
interface cpu_fetch_if;
    import cpu_pkg::*;

    addr_t       mem_addr;
    logic        mem_readwrite;
    data_t       mem_data;
    logic        branch_valid;
    addr_t       branch_addr;
    logic        instr_valid;
    logic        instr_ready;
    data_t       instr_opcode;
    logic [15:0] instr_operand;
    addr_t       instr_pc;
    logic        instr_illegal;

    modport master (
        output mem_addr, mem_readwrite,
        input  mem_data,
        input  branch_valid, branch_addr,
        output instr_valid, instr_opcode, instr_operand, instr_pc, instr_illegal,
        input  instr_ready
    );

    modport slave (
        input  mem_addr, mem_readwrite,
        output mem_data,
        output branch_valid, branch_addr,
        input  instr_valid, instr_opcode, instr_operand, instr_pc, instr_illegal,
        output instr_ready
    );

endinterface

// File: rtl/cpu_fetch.sv
// Instruction fetch stage.
// Issues one sequential byte read per cycle, assembles 1..3 byte instructions
// and holds the finished word on a valid/ready handshake. A one-byte skid
// register catches the read that was already in flight when the decoder stalls.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : cpu_fetch_if.master (memory port, branch request, decoder handshake)
// Parameter:
//   RESET_PC : byte address of the first fetch after reset
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter addr_t RESET_PC = 11'h000
) (
    input  logic        clk,
    input  logic        rst,
    cpu_fetch_if.master bus
);

    fetch_state_t state, state_nxt;
    addr_t        mem_addr_q, mem_addr_nxt;
    logic         pending, pending_nxt;
    logic         skid_full, skid_full_nxt;
    data_t        skid, skid_nxt;
    addr_t        byte_pc, byte_pc_nxt;    // address of the next byte to arrive
    data_t        op_q, op_nxt;
    data_t        arg1_q, arg1_nxt;
    addr_t        pc_q, pc_nxt;
    logic         valid_q, valid_nxt;
    data_t        out_op, out_op_nxt;
    logic [15:0]  out_operand, out_operand_nxt;
    addr_t        out_pc, out_pc_nxt;
    logic         out_ill, out_ill_nxt;

    logic         stall;
    logic         present;
    data_t        cur;
    logic [1:0]   len;

    assign stall   = valid_q && !bus.instr_ready;
    assign present = pending || skid_full;
    assign cur     = skid_full ? skid : bus.mem_data;
    assign len     = instr_len(cur);

    always_comb begin
        state_nxt       = state;
        mem_addr_nxt    = mem_addr_q;
        pending_nxt     = 1'b0;
        skid_full_nxt   = skid_full;
        skid_nxt        = skid;
        byte_pc_nxt     = byte_pc;
        op_nxt          = op_q;
        arg1_nxt        = arg1_q;
        pc_nxt          = pc_q;
        valid_nxt       = valid_q;
        out_op_nxt      = out_op;
        out_operand_nxt = out_operand;
        out_pc_nxt      = out_pc;
        out_ill_nxt     = out_ill;

        if (bus.branch_valid) begin
            // A transfer in this cycle still completes on the decoder side;
            // everything in flight is dropped.
            valid_nxt     = 1'b0;
            skid_full_nxt = 1'b0;
            state_nxt     = S_OP;
            mem_addr_nxt  = bus.branch_addr;
            byte_pc_nxt   = bus.branch_addr;
        end else begin
            if (valid_q && bus.instr_ready)
                valid_nxt = 1'b0;

            if (stall) begin
                // No issue while stalled, so at most one byte is ever in flight.
                if (pending) begin
                    skid_nxt      = bus.mem_data;
                    skid_full_nxt = 1'b1;
                end
            end else begin
                mem_addr_nxt = mem_addr_q + 11'd1;
                pending_nxt  = 1'b1;
                if (present) begin
                    skid_full_nxt = 1'b0;
                    byte_pc_nxt   = byte_pc + 11'd1;
                    case (state)
                        S_OP: begin
                            op_nxt = cur;
                            pc_nxt = byte_pc;
                            if (len == LEN_2 || len == LEN_3) begin
                                state_nxt = S_ARG1;
                            end else begin
                                out_op_nxt      = cur;
                                out_operand_nxt = '0;
                                out_pc_nxt      = byte_pc;
                                out_ill_nxt     = (len == LEN_ILL);
                                valid_nxt       = 1'b1;
                            end
                        end
                        S_ARG1: begin
                            if (instr_len(op_q) == LEN_3) begin
                                arg1_nxt  = cur;
                                state_nxt = S_ARG2;
                            end else begin
                                out_op_nxt      = op_q;
                                out_operand_nxt = {8'h00, cur};
                                out_pc_nxt      = pc_q;
                                out_ill_nxt     = 1'b0;
                                valid_nxt       = 1'b1;
                                state_nxt       = S_OP;
                            end
                        end
                        S_ARG2: begin
                            out_op_nxt      = op_q;
                            out_operand_nxt = {cur, arg1_q};
                            out_pc_nxt      = pc_q;
                            out_ill_nxt     = 1'b0;
                            valid_nxt       = 1'b1;
                            state_nxt       = S_OP;
                        end
                        default: state_nxt = S_OP;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OP;
            mem_addr_q  <= RESET_PC;
            pending     <= 1'b0;
            skid_full   <= 1'b0;
            skid        <= '0;
            byte_pc     <= RESET_PC;
            op_q        <= '0;
            arg1_q      <= '0;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            out_op      <= '0;
            out_operand <= '0;
            out_pc      <= '0;
            out_ill     <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_addr_q  <= mem_addr_nxt;
            pending     <= pending_nxt;
            skid_full   <= skid_full_nxt;
            skid        <= skid_nxt;
            byte_pc     <= byte_pc_nxt;
            op_q        <= op_nxt;
            arg1_q      <= arg1_nxt;
            pc_q        <= pc_nxt;
            valid_q     <= valid_nxt;
            out_op      <= out_op_nxt;
            out_operand <= out_operand_nxt;
            out_pc      <= out_pc_nxt;
            out_ill     <= out_ill_nxt;
        end
    end

    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_readwrite = 1'b1;
    assign bus.instr_valid   = valid_q;
    assign bus.instr_opcode  = out_op;
    assign bus.instr_operand = out_operand;
    assign bus.instr_pc      = out_pc;
    assign bus.instr_illegal = out_ill;

endmodule

// File: tb/tb_cpu_fetch.sv
// Testbench for cpu_fetch: directed scenarios plus a randomized run, checked
// every cycle against a byte-stream model of the fetch stage.
module tb_cpu_fetch;

    localparam logic [10:0] PC_MAIN = 11'h000;
    localparam logic [10:0] PC_WRAP = 11'h7FF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_fetch_if bus ();
    cpu_fetch_if bus_w ();

    cpu_fetch #(.RESET_PC(PC_MAIN)) dut   (.clk(clk), .rst(rst), .bus(bus));
    cpu_fetch #(.RESET_PC(PC_WRAP)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    logic [7:0] mem [0:2047];

    // Program memory: one-cycle read latency, shared by both instances.
    always @(posedge clk) begin
        bus.mem_data   <= mem[bus.mem_addr];
        bus_w.mem_data <= mem[bus_w.mem_addr];
    end

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    int unsigned e0 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // The stage delivers the byte stream starting at the fetch target at one
    // byte per non-stalled cycle, except the first cycle after a flush, which
    // only issues the read. Instructions are carved out of that stream.
    typedef struct {
        logic started;
        logic valid;
        int   op, opnd, pc;
        logic ill;
        int   addr, spc, start, cnt;
        logic warm;
    } model_t;

    model_t ms = '{default: 0};

    function automatic int len_of(logic [7:0] op);
        int code = int'(op) / 64;
        return (code == 3) ? 1 : code + 1;
    endfunction

    function automatic model_t model_step(model_t s, logic r, logic rdy, logic br, int baddr);
        model_t n = s;
        int     len;
        if (r) begin
            n = '{default: 0};
            n.addr = int'(PC_MAIN);
            n.spc = int'(PC_MAIN);
            n.started = 1'b1;
            return n;
        end
        if (s.valid && rdy) n.valid = 1'b0;
        if (br) begin
            n.valid = 1'b0;
            n.addr = baddr;
            n.spc = baddr;
            n.warm = 1'b0;
            n.cnt = 0;
        end else if (!(s.valid && !rdy)) begin
            n.addr = (s.addr + 1) % 2048;
            if (!s.warm) begin
                n.warm = 1'b1;
            end else begin
                if (s.cnt == 0) n.start = s.spc;
                n.cnt = s.cnt + 1;
                n.spc = (s.spc + 1) % 2048;
                len = len_of(mem[n.start]);
                if (n.cnt == len) begin
                    n.valid = 1'b1;
                    n.cnt = 0;
                    n.pc = n.start;
                    n.op = int'(mem[n.start]);
                    n.opnd = (len >= 2 ? int'(mem[(n.start + 1) % 2048]) : 0)
                           + (len == 3 ? int'(mem[(n.start + 2) % 2048]) * 256 : 0);
                    n.ill = (mem[n.start] >= 8'hC0);
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        ms <= model_step(ms, rst, bus.instr_ready, bus.branch_valid, int'(bus.branch_addr));

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (ms.started) begin
            chk("valid",     int'(bus.instr_valid),   int'(ms.valid));
            chk("opcode",    int'(bus.instr_opcode),  ms.op);
            chk("operand",   int'(bus.instr_operand), ms.opnd);
            chk("pc",        int'(bus.instr_pc),      ms.pc);
            chk("illegal",   int'(bus.instr_illegal), int'(ms.ill));
            chk("mem_addr",  int'(bus.mem_addr),      ms.addr);
            chk("readwrite", int'(bus.mem_readwrite), 1);
        end
    end

    // Transfer log, edges numbered from the last reset edge (E0).
    typedef struct {
        int edge_n;
        int pc;
        int op;
        int opnd;
    } xfer_t;
    xfer_t xq[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)
            e0 <= cyc + 1;
        else if (bus.instr_valid && bus.instr_ready)
            xq.push_back('{int'(cyc + 1 - e0), int'(bus.instr_pc),
                           int'(bus.instr_opcode), int'(bus.instr_operand)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic rst_on();
        @(negedge clk);
        rst = 1'b1;
        bus.branch_valid = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    endtask

    task automatic rst_off();
        @(negedge clk);
        rst = 1'b0;
        xq.delete();
    endtask

    // Returns at the negedge following edge E<n>.
    task automatic wait_edge(input int unsigned n);
        while (cyc - e0 < n) @(negedge clk);
    endtask

    task automatic load_basic();
        mem[0] = 8'h01;
        mem[1] = 8'h40; mem[2] = 8'h34;
        mem[3] = 8'h80; mem[4] = 8'hCD; mem[5] = 8'hAB;
    endtask

    task automatic chk_basic_xfers(input string tag, input logic with_edges);
        chk({tag, " count>=3"}, int'(xq.size() >= 3), 1);
        if (xq.size() >= 3) begin
            chk({tag, " pc0"}, xq[0].pc, 0);     chk({tag, " op0"}, xq[0].op, 'h01); chk({tag, " opnd0"}, xq[0].opnd, 'h0000);
            chk({tag, " pc1"}, xq[1].pc, 1);     chk({tag, " op1"}, xq[1].op, 'h40); chk({tag, " opnd1"}, xq[1].opnd, 'h0034);
            chk({tag, " pc2"}, xq[2].pc, 3);     chk({tag, " op2"}, xq[2].op, 'h80); chk({tag, " opnd2"}, xq[2].opnd, 'hABCD);
            if (with_edges) begin
                // valid after E2/E4/E7, accepted on the following edge
                chk({tag, " edge0"}, xq[0].edge_n, 2 + 1);
                chk({tag, " edge1"}, xq[1].edge_n, 4 + 1);
                chk({tag, " edge2"}, xq[2].edge_n, 7 + 1);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    initial begin
        bus.instr_ready = 1'b1; bus.branch_valid = 1'b0; bus.branch_addr = '0;
        bus_w.instr_ready = 1'b1; bus_w.branch_valid = 1'b0; bus_w.branch_addr = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        // 1: basic stream, ready high
        rst_on(); load_basic(); rst_off();
        chk("t1 reset valid", int'(bus.instr_valid), 0);
        chk("t1 reset addr", int'(bus.mem_addr), 0);
        wait_edge(10);
        chk_basic_xfers("t1", 1'b1);

        // 2: stall for 5 cycles at the first valid
        rst_on(); load_basic(); rst_off();
        for (int i = 0; i < 20 && !bus.instr_valid; i++) @(negedge clk);
        chk("t2 first valid", int'(bus.instr_valid), 1);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2 stall valid", int'(bus.instr_valid), 1);
            chk("t2 stall op", int'(bus.instr_opcode), 'h01);
            chk("t2 stall pc", int'(bus.instr_pc), 0);
            chk("t2 stall addr", int'(bus.mem_addr), 2);
            @(negedge clk);
        end
        bus.instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk_basic_xfers("t2", 1'b0);

        // 3: address wrap from RESET_PC = 0x7FF
        rst_on(); mem[11'h7FF] = 8'h40; mem[0] = 8'h12; rst_off();
        wait_edge(1);
        chk("t3 wrap addr", int'(bus_w.mem_addr), 'h000);
        wait_edge(2);
        chk("t3 early valid", int'(bus_w.instr_valid), 0);
        wait_edge(3);
        chk("t3 valid", int'(bus_w.instr_valid), 1);
        chk("t3 pc", int'(bus_w.instr_pc), 'h7FF);
        chk("t3 op", int'(bus_w.instr_opcode), 'h40);
        chk("t3 opnd", int'(bus_w.instr_operand), 'h0012);
        chk("t3 ill", int'(bus_w.instr_illegal), 0);

        // 4: branch while waiting for operand byte 1
        rst_on();
        mem[0] = 8'h80; mem[1] = 8'h11; mem[2] = 8'h22;
        mem[11'h100] = 8'h00; mem[11'h101] = 8'h3F;
        rst_off();
        wait_edge(2);
        bus.branch_valid = 1'b1; bus.branch_addr = 11'h100;
        wait_edge(3);
        bus.branch_valid = 1'b0;
        chk("t4 valid E3", int'(bus.instr_valid), 0);
        wait_edge(4);
        chk("t4 valid E4", int'(bus.instr_valid), 0);
        wait_edge(5);
        chk("t4 valid E5", int'(bus.instr_valid), 1);
        chk("t4 pc", int'(bus.instr_pc), 'h100);
        chk("t4 op", int'(bus.instr_opcode), 'h00);
        wait_edge(7);
        chk("t4 count>=1", int'(xq.size() >= 1), 1);
        if (xq.size() >= 1) chk("t4 first pc", xq[0].pc, 'h100);

        // 5: branch in the same cycle as a transfer
        rst_on();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        mem[11'h200] = 8'h05;
        rst_off();
        wait_edge(3);
        chk("t5 pre pc", int'(bus.instr_pc), 1);
        bus.branch_valid = 1'b1; bus.branch_addr = 11'h200;
        wait_edge(4);
        bus.branch_valid = 1'b0;
        chk("t5 flushed", int'(bus.instr_valid), 0);
        wait_edge(6);
        chk("t5 valid", int'(bus.instr_valid), 1);
        chk("t5 pc", int'(bus.instr_pc), 'h200);
        chk("t5 op", int'(bus.instr_opcode), 'h05);
        wait_edge(7);
        chk("t5 count", xq.size(), 3);
        if (xq.size() == 3) begin
            chk("t5 x0", xq[0].pc, 0);
            chk("t5 x1", xq[1].pc, 1);
            chk("t5 x2", xq[2].pc, 'h200);
        end

        // 6: illegal opcode, then reset while stalled
        rst_on();
        mem[0] = 8'hC5; mem[1] = 8'h40; mem[2] = 8'h99;
        bus.instr_ready = 1'b0;
        rst_off();
        wait_edge(2);
        chk("t6 valid", int'(bus.instr_valid), 1);
        chk("t6 op", int'(bus.instr_opcode), 'hC5);
        chk("t6 ill", int'(bus.instr_illegal), 1);
        chk("t6 opnd", int'(bus.instr_operand), 0);
        chk("t6 pc", int'(bus.instr_pc), 0);
        wait_edge(5);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 rst valid", int'(bus.instr_valid), 0);
        chk("t6 rst op", int'(bus.instr_opcode), 0);
        chk("t6 rst opnd", int'(bus.instr_operand), 0);
        chk("t6 rst pc", int'(bus.instr_pc), 0);
        chk("t6 rst ill", int'(bus.instr_illegal), 0);
        chk("t6 rst addr", int'(bus.mem_addr), 0);
        rst = 1'b0;
        xq.delete();
        bus.instr_ready = 1'b1;
        wait_edge(3);
        chk("t6 restart count>=1", int'(xq.size() >= 1), 1);
        if (xq.size() >= 1) chk("t6 restart pc", xq[0].pc, 0);

        // 7: randomized image, ready, branches and resets
        rst_on();
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
        rst_off();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.instr_ready  = ($urandom_range(0, 99) < 70);
            bus.branch_valid = ($urandom_range(0, 99) < 4);
            bus.branch_addr  = 11'($urandom_range(0, 2047));
            rst              = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0; bus.branch_valid = 1'b0;
        chk("t7 transfers>100", int'(xq.size() > 100), 1);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
